entrada_controller: RTL and testbench
=====================================

Name: entrada_controller

Overview:
- Sequences the processor's IN instruction against the input datapath: the 14-bit switch bank plus the debounced confirm button, and the PS/2 keyboard byte stream.
- Buffers keyboard make-codes in a small FIFO and drops break sequences.
- Stalls the CPU with busy until the requested source produces a value, then returns it with a one-cycle rd_valid pulse.
- Sits between the CPU input-instruction decode and the raw PS/2 and switch/button logic.

Parameters:
- FIFO_DEPTH, 8, keyboard FIFO entries (power of 2, >= 2).
- SW_W, 14, switch bank width.
- BREAK_CODE, 8'hF0, PS/2 break prefix byte.

Ports:
- Clock  in  1  system clock; all logic on posedge.
- Reset_n  in  1  asynchronous, active-low reset.
- req  in  1  CPU input request (level; sampled only in IDLE).
- req_src  in  2  source select: 1 = switches, 2 = keyboard, 0/3 = none.
- sw_value  in  SW_W  switch bank value.
- sw_confirm  in  1  debounced confirm button, active-high level.
- kb_data  in  8  PS/2 received byte.
- kb_valid  in  1  one-cycle strobe qualifying kb_data.
- flush  in  1  clear FIFO, break state and overflow flag.
- rd_data  out  32  returned value, zero-extended.
- rd_valid  out  1  one-cycle result strobe.
- busy  out  1  CPU stall request.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky: a keyboard byte was dropped because the FIFO was full.

Behaviour:
- Reset (async, Reset_n=0):
  - state=IDLE; rd_data=0; rd_valid=0; busy=0; fifo_count=0; overflow=0.
  - break_pending=0; confirm_prev=1.
- FSM states: IDLE, WAIT_SW, WAIT_KB, RESP.
  - IDLE, req=1:
    - req_src=1 -> WAIT_SW.
    - req_src=2 -> WAIT_KB.
    - req_src=0 or 3 -> RESP with rd_data=0.
  - IDLE, req=0 -> stay in IDLE.
  - WAIT_SW: on a rising edge of sw_confirm (sw_confirm=1 and confirm_prev=0), rd_data <= {0, sw_value} -> RESP.
  - WAIT_KB: if the registered fifo_count is nonzero, pop the head, rd_data <= {24'd0, head} -> RESP. Otherwise stay.
  - RESP: rd_valid=1 for exactly this cycle; next state is IDLE. req is ignored in RESP, so a back-to-back request is accepted the cycle after RESP.
- busy (combinational) = (IDLE and req) or WAIT_SW or WAIT_KB. busy=0 in RESP.
- rd_data holds its last value outside RESP.
- confirm_prev <= sw_confirm every cycle. Its reset value of 1 means a button held through reset needs a release before it can confirm.
- Latency:
  - Keyboard request with non-empty FIFO: req at cycle N, rd_valid at N+2.
  - Switch request: rd_valid one cycle after the confirm edge is seen in WAIT_SW.
  - Invalid source: rd_valid at N+1.
- Keyboard push filter, on kb_valid:
  - kb_data==BREAK_CODE -> set break_pending; the byte is not pushed.
  - Otherwise, break_pending=1 -> discard the byte and clear break_pending.
  - Otherwise, push the byte.
- FIFO boundaries:
  - Push while full with no pop that cycle: byte dropped, overflow <= 1.
  - Push and pop in the same cycle while full: both succeed, count unchanged, no overflow.
  - Pop is gated by the registered count. On an empty FIFO with a push in the same cycle, only the push occurs; the pop happens the next cycle.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - fifo_count saturates neither below 0 nor above FIFO_DEPTH.
- flush (synchronous):
  - Empties the FIFO and clears break_pending and overflow.
  - Has priority over a same-cycle push and pop.
  - Does not change FSM state; WAIT_KB keeps waiting for new bytes.
- Reset asserted mid-transaction: immediate return to IDLE with busy=0. The pending CPU request is abandoned and the CPU must reissue it.

Decomposition:
- Package entrada_pkg holds:
  - state enum (IDLE, WAIT_SW, WAIT_KB, RESP).
  - source codes SRC_NONE=2'd0, SRC_SW=2'd1, SRC_KB=2'd2.
  - BREAK_CODE default 8'hF0.
- Sub-module kb_fifo: parameterised synchronous FIFO.
  - Inputs: push, pop, flush, din.
  - Outputs: dout, count, full, empty, with the simultaneous-access rules above.
- The FSM, edge detector and break filter stay in entrada_controller.

Test Plan:
- Keyboard bytes 8'h1C, 8'hF0, 8'h1C, 8'h32 via kb_valid -> fifo_count=2. Two keyboard requests return rd_data=32'h1C then 32'h32, each rd_valid 2 cycles after req.
- Keyboard request with empty FIFO -> busy held high. Push 8'h45 -> rd_valid with 32'h45 two cycles after the push strobe; busy low in the RESP cycle.
- Switch request with sw_value=14'h1ABC and sw_confirm held high from before req -> busy stays high. Release, then press -> rd_data=32'h00001ABC one cycle after the edge.
- Push 9 bytes 8'h01..8'h09 with no reads -> fifo_count=8 and overflow=1. Reads return 01..08. flush -> overflow=0, fifo_count=0.
- With the FIFO full, push and pop in the same cycle -> count stays 8 and overflow stays 0. req_src=3 -> rd_data=0, rd_valid at N+1.
- Assert Reset_n=0 during WAIT_SW -> busy=0, rd_valid=0 and fifo_count=0 immediately. After release, the state is IDLE and a new keyboard request works.

Source files
------------

// File: rtl/entrada_pkg.sv
// Shared types and constants for the IN-instruction input controller.
package entrada_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_SW = 2'd1,
      WAIT_KB = 2'd2,
      RESP    = 2'd3
   } state_t;

   localparam logic [1:0] SRC_NONE = 2'd0;
   localparam logic [1:0] SRC_SW   = 2'd1;
   localparam logic [1:0] SRC_KB   = 2'd2;

   localparam logic [7:0] BREAK_CODE_DEFAULT = 8'hF0;

endpackage

// File: rtl/entrada_controller_kb_fifo.sv
// Synchronous FIFO for keyboard make-codes; a push into a full FIFO only
// succeeds when a pop frees a slot in the same cycle, and flush wins over both.
module kb_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [W-1:0]             din,
   output logic [W-1:0]             dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          push_ok, pop_ok;

   assign full  = (count_q == CNT_FULL);
   assign empty = (count_q == '0);
   assign dout  = mem_q[rd_ptr_q];
   assign count = count_q;

   always_comb begin
      pop_ok   = pop && !flush && !empty;
      push_ok  = push && !flush && (!full || pop_ok);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
         case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is left unreset; occupancy alone decides what is readable.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/entrada_controller.sv
// Serves the CPU IN instruction from the switch bank (on a confirm press) or
// from the keyboard make-code FIFO, stalling with busy until a value is ready.
module entrada_controller
   import entrada_pkg::*;
#(
   parameter int         FIFO_DEPTH = 8,
   parameter int         SW_W       = 14,
   parameter logic [7:0] BREAK_CODE = BREAK_CODE_DEFAULT
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          req,
   input  logic [1:0]                    req_src,
   input  logic [SW_W-1:0]               sw_value,
   input  logic                          sw_confirm,
   input  logic [7:0]                    kb_data,
   input  logic                          kb_valid,
   input  logic                          flush,
   output logic [31:0]                   rd_data,
   output logic                          rd_valid,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow
);

   state_t      state_q, state_d;
   logic [31:0] rd_data_q, rd_data_d;
   logic        rd_valid_q, rd_valid_d;
   logic        confirm_prev_q;
   logic        break_pending_q, break_pending_d;
   logic        overflow_q, overflow_d;
   logic        kb_push, kb_pop;
   logic        fifo_full, fifo_empty;
   logic [7:0]  fifo_dout;

   kb_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (8)
   ) u_kb_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (kb_push),
      .pop   (kb_pop),
      .flush (flush),
      .din   (kb_data),
      .dout  (fifo_dout),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // A break prefix swallows itself and the key code that follows it.
   always_comb begin
      break_pending_d = break_pending_q;
      kb_push         = 1'b0;
      if (flush) begin
         break_pending_d = 1'b0;
      end else if (kb_valid) begin
         if (kb_data == BREAK_CODE)  break_pending_d = 1'b1;
         else if (break_pending_q)   break_pending_d = 1'b0;
         else                        kb_push         = 1'b1;
      end
   end

   assign kb_pop     = (state_q == WAIT_KB) && !fifo_empty && !flush;
   assign overflow_d = flush ? 1'b0 : (overflow_q | (kb_push & fifo_full & ~kb_pop));

   always_comb begin
      state_d   = state_q;
      rd_data_d = rd_data_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               case (req_src)
                  SRC_SW:   state_d = WAIT_SW;
                  SRC_KB:   state_d = WAIT_KB;
                  SRC_NONE: begin state_d = RESP; rd_data_d = '0; end
                  default:  begin state_d = RESP; rd_data_d = '0; end
               endcase
            end
         end
         WAIT_SW: begin
            if (sw_confirm && !confirm_prev_q) begin
               rd_data_d = {{(32-SW_W){1'b0}}, sw_value};
               state_d   = RESP;
            end
         end
         WAIT_KB: begin
            if (kb_pop) begin
               rd_data_d = {24'd0, fifo_dout};
               state_d   = RESP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      rd_valid_d = (state_d == RESP);
   end

   // confirm_prev resets high so a button held through reset must be released first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= IDLE;
         rd_data_q       <= '0;
         rd_valid_q      <= 1'b0;
         confirm_prev_q  <= 1'b1;
         break_pending_q <= 1'b0;
         overflow_q      <= 1'b0;
      end else begin
         state_q         <= state_d;
         rd_data_q       <= rd_data_d;
         rd_valid_q      <= rd_valid_d;
         confirm_prev_q  <= sw_confirm;
         break_pending_q <= break_pending_d;
         overflow_q      <= overflow_d;
      end
   end

   assign busy     = ((state_q == IDLE) && req) || (state_q == WAIT_SW) || (state_q == WAIT_KB);
   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_entrada_controller.sv
// Directed bench for entrada_controller: keyboard filtering and FIFO limits,
// switch confirm edges, invalid sources, flush and asynchronous reset.
module tb_entrada_controller;

   logic        clk;
   logic        rst_n;
   logic        req;
   logic [1:0]  req_src;
   logic [13:0] sw_value;
   logic        sw_confirm;
   logic [7:0]  kb_data;
   logic        kb_valid;
   logic        flush;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic        busy;
   logic [3:0]  fifo_count;
   logic        overflow;

   int total = 0;
   int bad   = 0;

   entrada_controller #(
      .FIFO_DEPTH (8),
      .SW_W       (14),
      .BREAK_CODE (8'hF0)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
      .req_src    (req_src),
      .sw_value   (sw_value),
      .sw_confirm (sw_confirm),
      .kb_data    (kb_data),
      .kb_valid   (kb_valid),
      .flush      (flush),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .busy       (busy),
      .fifo_count (fifo_count),
      .overflow   (overflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Inputs change and outputs are sampled 1ns after each rising edge.
   task automatic stepClock();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [7:0] b);
      kb_data  = b;
      kb_valid = 1'b1;
      stepClock();
      kb_valid = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      req        = 1'b0;
      req_src    = 2'd0;
      sw_value   = '0;
      sw_confirm = 1'b0;
      kb_data    = '0;
      kb_valid   = 1'b0;
      flush      = 1'b0;
      stepClock();
      stepClock();
      checkOutput("rst_busy",     busy,       0);
      checkOutput("rst_rd_valid", rd_valid,   0);
      checkOutput("rst_rd_data",  rd_data,    0);
      checkOutput("rst_count",    fifo_count, 0);
      checkOutput("rst_overflow", overflow,   0);
      rst_n = 1'b1;
      stepClock();

      // Break filter: 1C, F0, 1C, 32 leaves 1C and 32
      applyStimulus(8'h1C);
      applyStimulus(8'hF0);
      applyStimulus(8'h1C);
      applyStimulus(8'h32);
      checkOutput("filter_count", fifo_count, 2);
      req = 1'b1; req_src = 2'd2;
      #1;
      checkOutput("kb1_busy_idle", busy, 1);
      stepClock();
      req = 1'b0;
      checkOutput("kb1_wait_valid", rd_valid, 0);
      checkOutput("kb1_wait_busy",  busy,     1);
      stepClock();
      checkOutput("kb1_valid", rd_valid,   1);
      checkOutput("kb1_data",  rd_data,    32'h1C);
      checkOutput("kb1_busy",  busy,       0);
      checkOutput("kb1_count", fifo_count, 1);
      stepClock();
      checkOutput("kb1_valid_drop", rd_valid, 0);
      checkOutput("kb1_data_hold",  rd_data,  32'h1C);
      req = 1'b1; req_src = 2'd2;
      stepClock();
      req = 1'b0;
      stepClock();
      checkOutput("kb2_valid", rd_valid,   1);
      checkOutput("kb2_data",  rd_data,    32'h32);
      checkOutput("kb2_count", fifo_count, 0);
      stepClock();

      // Keyboard request against an empty FIFO stalls until a byte arrives
      req = 1'b1; req_src = 2'd2;
      stepClock();
      req = 1'b0;
      stepClock();
      stepClock();
      stepClock();
      checkOutput("kbwait_busy",  busy,     1);
      checkOutput("kbwait_valid", rd_valid, 0);
      applyStimulus(8'h45);
      checkOutput("kbwait_push_valid", rd_valid, 0);
      stepClock();
      checkOutput("kbwait_valid2", rd_valid, 1);
      checkOutput("kbwait_data",   rd_data,  32'h45);
      checkOutput("kbwait_busy2",  busy,     0);
      stepClock();

      // Switch request with the button already held: needs release then press
      sw_confirm = 1'b1;
      sw_value   = 14'h1ABC;
      stepClock();
      req = 1'b1; req_src = 2'd1;
      stepClock();
      req = 1'b0;
      stepClock();
      stepClock();
      checkOutput("sw_held_busy",  busy,     1);
      checkOutput("sw_held_valid", rd_valid, 0);
      sw_confirm = 1'b0;
      stepClock();
      checkOutput("sw_release_busy", busy, 1);
      sw_confirm = 1'b1;
      stepClock();
      checkOutput("sw_valid", rd_valid, 1);
      checkOutput("sw_data",  rd_data,  32'h00001ABC);
      stepClock();
      sw_confirm = 1'b0;
      checkOutput("sw_after_valid", rd_valid, 0);

      // Overflow: nine pushes into eight slots
      for (int i = 1; i <= 9; i++) applyStimulus(8'(i));
      checkOutput("ovf_count", fifo_count, 8);
      checkOutput("ovf_flag",  overflow,   1);
      for (int i = 1; i <= 8; i++) begin
         req = 1'b1; req_src = 2'd2;
         stepClock();
         req = 1'b0;
         stepClock();
         checkOutput($sformatf("ovf_read%0d", i), rd_data, 32'(i));
         stepClock();
      end
      checkOutput("ovf_drained", fifo_count, 0);
      checkOutput("ovf_sticky",  overflow,   1);
      applyStimulus(8'hF0);
      flush = 1'b1;
      stepClock();
      flush = 1'b0;
      checkOutput("flush_overflow", overflow,   0);
      checkOutput("flush_count",    fifo_count, 0);
      applyStimulus(8'h11);
      checkOutput("flush_break_clr", fifo_count, 1);
      flush = 1'b1;
      stepClock();
      flush = 1'b0;
      checkOutput("flush_count2", fifo_count, 0);

      // Full FIFO with push and pop in the same cycle
      for (int i = 0; i < 8; i++) applyStimulus(8'h20 + 8'(i));
      checkOutput("full_count", fifo_count, 8);
      req = 1'b1; req_src = 2'd2;
      stepClock();
      req = 1'b0;
      applyStimulus(8'h28);
      checkOutput("full_pp_count",    fifo_count, 8);
      checkOutput("full_pp_overflow", overflow,   0);
      checkOutput("full_pp_data",     rd_data,    32'h20);
      checkOutput("full_pp_valid",    rd_valid,   1);
      stepClock();

      // Invalid source answers zero one cycle later
      req = 1'b1; req_src = 2'd3;
      #1;
      checkOutput("inv_busy", busy, 1);
      stepClock();
      req = 1'b0;
      checkOutput("inv_valid", rd_valid, 1);
      checkOutput("inv_data",  rd_data,  0);
      stepClock();
      checkOutput("inv_valid_drop", rd_valid, 0);

      // Asynchronous reset during WAIT_SW
      req = 1'b1; req_src = 2'd1;
      stepClock();
      req = 1'b0;
      stepClock();
      checkOutput("rstmid_busy_pre", busy, 1);
      rst_n = 1'b0;
      #1;
      checkOutput("rstmid_busy",     busy,       0);
      checkOutput("rstmid_valid",    rd_valid,   0);
      checkOutput("rstmid_count",    fifo_count, 0);
      checkOutput("rstmid_overflow", overflow,   0);
      stepClock();
      rst_n = 1'b1;
      stepClock();
      checkOutput("rstmid_idle_busy", busy, 0);
      applyStimulus(8'h66);
      req = 1'b1; req_src = 2'd2;
      stepClock();
      req = 1'b0;
      stepClock();
      checkOutput("post_rst_valid", rd_valid, 1);
      checkOutput("post_rst_data",  rd_data,  32'h66);
      stepClock();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
